// File: rtl/obi_data_mem.sv
// obi_data_mem
// OBI subordinate data memory for the core MEM-stage initiator port.
// Word-organised synchronous RAM with byte-enable writes, a fixed
// grant-to-response latency and a bounded number of outstanding transactions.
//
// Ports:
//   clk_i     system clock
//   rstn_i    asynchronous active-low reset
//   stall_i   grant inhibit (1: deny grant this cycle)
//   req_i     address-phase request
//   gnt_o     grant (combinational); accept = req_i && gnt_o at the rising edge
//   addr_i    byte address
//   we_i      1: write, 0: read
//   wdata_i   write data
//   be_i      byte enables
//   rvalid_o  response valid, one pulse per accepted transaction
//   rdata_o   read data (0 for writes and errors)
//   err_o     error response, qualified by rvalid_o
module obi_data_mem #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    DEPTH_WORDS     = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    LATENCY         = 1,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    stall_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS * BYTES);
    localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  pipe_valid [LATENCY];
    logic [DATA_WIDTH-1:0] pipe_rdata [LATENCY];
    logic                  pipe_err   [LATENCY];

    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  addr_err;
    logic [IDX_W-1:0]      word_idx;
    logic                  accept;

    // Base is aligned to the memory size, so alignment of addr_i and offset agree.
    assign offset       = addr_i - BASE_ADDR;
    assign out_of_range = {1'b0, offset} >= MEM_BYTES;
    assign misaligned   = |addr_i[OFF_W-1:0];
    assign addr_err     = out_of_range || misaligned;
    assign word_idx     = offset[OFF_W +: IDX_W];

    // A response issuing this cycle frees its slot immediately, so a full
    // counter still grants when rvalid_o is high.
    assign gnt_o  = rstn_i && req_i && !stall_i && ((count < MAX_CNT) || rvalid_o);
    assign accept = req_i && gnt_o;

    // RAM contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !addr_err) begin
            for (int k = 0; k < BYTES; k++) begin
                if (be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Read data is captured at the accept edge, before any same-edge write,
    // and then travels down the pipeline untouched.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_rdata[s] <= '0;
                pipe_err[s]   <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && addr_err;
            pipe_rdata[0] <= (accept && !we_i && !addr_err) ? mem[word_idx] : '0;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_rdata[s] <= pipe_rdata[s-1];
                pipe_err[s]   <= pipe_err[s-1];
            end
        end
    end

    assign rvalid_o = pipe_valid[LATENCY-1];
    assign rdata_o  = pipe_rdata[LATENCY-1];
    assign err_o    = pipe_err[LATENCY-1];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count <= '0;
        end else begin
            case ({accept, rvalid_o})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_data_mem.sv
module tb_obi_data_mem;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int NI = 3;
    localparam int LAT  [NI] = '{1, 3, 2};
    localparam int MAXO [NI] = '{2, 2, 1};

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic [NI-1:0] gnt;
    logic [NI-1:0] rvalid;
    logic [NI-1:0] err;
    logic [31:0]   rdata [NI];

    rsp_t        q [NI][$];
    logic [31:0] mm [NI][1024];
    int          obs_cnt [NI];
    int          cyc;
    int          n_assert;
    int          n_fail;
    logic [5:0]  gpat;

    obi_data_mem #(.BASE_ADDR(BASE), .LATENCY(1), .MAX_OUTSTANDING(2)) u_l1 (
        .clk_i(clk), .rstn_i(rstn), .stall_i(stall), .req_i(req), .gnt_o(gnt[0]),
        .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    obi_data_mem #(.BASE_ADDR(BASE), .LATENCY(3), .MAX_OUTSTANDING(2)) u_l3 (
        .clk_i(clk), .rstn_i(rstn), .stall_i(stall), .req_i(req), .gnt_o(gnt[1]),
        .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    obi_data_mem #(.BASE_ADDR(BASE), .LATENCY(2), .MAX_OUTSTANDING(1)) u_l2 (
        .clk_i(clk), .rstn_i(rstn), .stall_i(stall), .req_i(req), .gnt_o(gnt[2]),
        .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
        .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, check just after, then let the
    // model absorb whatever the next rising edge accepts.
    task automatic step(input logic rq, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input logic st);
        @(negedge clk);
        req = rq; we = w; addr = a; wdata = wd; be = b; stall = st;
        #1;
        for (int i = 0; i < NI; i++) begin
            int          pend;
            logic        eg;
            logic        e;
            logic [31:0] off;
            rsp_t        r;
            pend = 0;
            for (int j = 0; j < q[i].size(); j++)
                if (q[i][j].due > cyc) pend++;
            eg = rq && !st && (pend < MAXO[i]);
            chk($sformatf("gnt[%0d]", i), {31'b0, gnt[i]}, {31'b0, eg});
            if (q[i].size() > 0 && q[i][0].due == cyc) begin
                r = q[i].pop_front();
                chk($sformatf("rvalid[%0d]", i), {31'b0, rvalid[i]}, 32'd1);
                chk($sformatf("rdata[%0d]", i), rdata[i], r.data);
                chk($sformatf("err[%0d]", i), {31'b0, err[i]}, {31'b0, r.err});
            end else begin
                chk($sformatf("rvalid_idle[%0d]", i), {31'b0, rvalid[i]}, 32'd0);
                chk($sformatf("rdata_idle[%0d]", i), rdata[i], 32'd0);
                chk($sformatf("err_idle[%0d]", i), {31'b0, err[i]}, 32'd0);
            end
            obs_cnt[i] += (rq && gnt[i]) ? 1 : 0;
            obs_cnt[i] -= rvalid[i] ? 1 : 0;
            chk($sformatf("outstanding_bound[%0d]", i), {31'b0, (obs_cnt[i] <= MAXO[i])}, 32'd1);
            if (eg) begin
                off = a - BASE;
                e   = (off >= 32'd4096) || (a[1:0] != 2'b00);
                r.due  = cyc + LAT[i];
                r.err  = e;
                r.data = (!w && !e) ? mm[i][off[11:2]] : 32'd0;
                if (w && !e)
                    for (int k = 0; k < 4; k++)
                        if (b[k]) mm[i][off[11:2]][8*k +: 8] = wd[8*k +: 8];
                q[i].push_back(r);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b0, a, 32'h5A5A_5A5A, 4'hF, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        step(1'b1, 1'b1, a, d, b, 1'b0);
    endtask

    // Reset asserted for one cycle with a request pending; everything in flight
    // is dropped and nothing may be granted or issued meanwhile.
    task automatic reset_pulse();
        @(negedge clk);
        rstn = 1'b0; req = 1'b1; we = 1'b0; addr = BASE; stall = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_gnt[%0d]", i), {31'b0, gnt[i]}, 32'd0);
            chk($sformatf("rst_rvalid[%0d]", i), {31'b0, rvalid[i]}, 32'd0);
            chk($sformatf("rst_rdata[%0d]", i), rdata[i], 32'd0);
            chk($sformatf("rst_err[%0d]", i), {31'b0, err[i]}, 32'd0);
            q[i].delete();
            obs_cnt[i] = 0;
        end
        cyc++;
        @(negedge clk);
        rstn = 1'b1; req = 1'b0;
        cyc++;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        n_assert = 0; n_fail = 0; cyc = 0;
        rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; stall = 1'b0;
        for (int i = 0; i < NI; i++) obs_cnt[i] = 0;

        reset_pulse();

        // Give words 0..15 known contents in every instance.
        for (int w = 0; w < 16; w++) begin
            wr(BASE + 32'(4 * w), $urandom, 4'hF);
            idle(3);
        end

        // Write then read the same word back to back.
        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(BASE + 32'h10);
        idle(4);

        // Byte-enable merge: 0x11223344 with 0xAABBCCDD under be=0101.
        wr(BASE + 32'h14, 32'h1122_3344, 4'hF);
        idle(3);
        wr(BASE + 32'h14, 32'hAABB_CCDD, 4'b0101);
        idle(3);
        rd(BASE + 32'h14);
        idle(4);

        // Error responses: misaligned read, out-of-range write, word 0 intact.
        rd(BASE + 32'h2);
        idle(3);
        wr(BASE + 32'd4096, 32'hCAFE_F00D, 4'hF);
        idle(3);
        rd(BASE);
        idle(4);

        // Back-pressure with req held high for six cycles.
        for (int k = 0; k < 6; k++) begin
            rd(BASE + 32'(4 * k));
            gpat[5-k] = gnt[1];
        end
        chk("l3_gnt_pattern", {26'b0, gpat}, {26'b0, 6'b110110});
        idle(6);

        // Stall for three cycles, then release with req still high.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, BASE + 32'h8, 32'd0, 4'hF, 1'b1);
        rd(BASE + 32'h8);
        chk("stall_release_gnt", {29'b0, gnt}, 32'd7);
        idle(4);

        // Reset one cycle after a read accept drops that read's response.
        rd(BASE + 32'h4);
        reset_pulse();
        idle(5);
        rd(BASE + 32'h4);
        chk("post_reset_gnt", {29'b0, gnt}, 32'd7);
        idle(4);

        // Randomised traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      a = BASE + 32'(4 * $urandom_range(0, 15));
            else if (r < 88) a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if (r < 94) a = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 15));
            else             a = BASE - 32'(4 * $urandom_range(1, 4));
            step(($urandom_range(0, 9) < 8), 1'($urandom), a, $urandom,
                 4'($urandom), ($urandom_range(0, 6) == 0));
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
